// File: rtl/reg_native_arb_pkg.sv
// Shared types for the native-bus arbiter.
//   arb_state_e    : arbiter FSM states
//   ERR_RD_DATA    : read data returned with every error response
//   is_illegal_cmd : a command that is neither a pure read nor a pure write
package reg_native_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  localparam int unsigned ERR_RD_DATA = 0;

  function automatic logic is_illegal_cmd(input logic wr, input logic rd);
    return wr == rd;
  endfunction

endpackage

// File: rtl/reg_native_if_arb_if.sv
// Native register bus bundle: N upstream ports (packed, port 0 in LSBs)
// plus one downstream port.
//   slave  : arbiter side (takes upstream requests, drives downstream)
//   master : environment side (drives upstream requests and downstream acks)
interface reg_native_if_arb_if #(
  parameter int N_PORTS        = 4,
  parameter int BUS_ADDR_WIDTH = 64,
  parameter int BUS_DATA_WIDTH = 32
);
  logic [N_PORTS-1:0]                up_req_vld, up_wr_en, up_rd_en, up_non_sec;
  logic [N_PORTS*BUS_ADDR_WIDTH-1:0] up_addr;
  logic [N_PORTS*BUS_DATA_WIDTH-1:0] up_wr_data;
  logic [N_PORTS-1:0]                up_ack_vld, up_err;
  logic [N_PORTS*BUS_DATA_WIDTH-1:0] up_rd_data;

  logic                              dn_req_vld, dn_wr_en, dn_rd_en, dn_non_sec;
  logic [BUS_ADDR_WIDTH-1:0]         dn_addr;
  logic [BUS_DATA_WIDTH-1:0]         dn_wr_data;
  logic                              dn_ack_vld, dn_err;
  logic [BUS_DATA_WIDTH-1:0]         dn_rd_data;

  modport slave (
    input  up_req_vld, up_wr_en, up_rd_en, up_non_sec, up_addr, up_wr_data,
    output up_ack_vld, up_err, up_rd_data,
    output dn_req_vld, dn_wr_en, dn_rd_en, dn_non_sec, dn_addr, dn_wr_data,
    input  dn_ack_vld, dn_err, dn_rd_data
  );

  modport master (
    output up_req_vld, up_wr_en, up_rd_en, up_non_sec, up_addr, up_wr_data,
    input  up_ack_vld, up_err, up_rd_data,
    input  dn_req_vld, dn_wr_en, dn_rd_en, dn_non_sec, dn_addr, dn_wr_data,
    output dn_ack_vld, dn_err, dn_rd_data
  );
endinterface

// File: rtl/reg_native_if_arb_rr_arbiter.sv
// Round-robin pick: first pending index strictly after i_ptr, wrapping.
//   i_pend    : pending request vector
//   i_ptr     : last granted index
//   o_gnt_oh  : one-hot grant (all zero when nothing pending)
//   o_gnt_idx : grant index
module rr_arbiter #(
  parameter int N = 4
)(
  input  logic [N-1:0]         i_pend,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt_oh,
  output logic [$clog2(N)-1:0] o_gnt_idx
);
  localparam int IW = $clog2(N);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;
  logic          w_found;

  // Walk candidates ptr+1 .. ptr+N (mod N); first hit wins.
  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum  = {1'b0, i_ptr} + (IW+1)'(k);
      w_cand = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
      if (!w_found && i_pend[w_cand]) begin
        w_found          = 1'b1;
        o_gnt_oh[w_cand] = 1'b1;
        o_gnt_idx        = w_cand;
      end
    end
  end
endmodule

// File: rtl/reg_native_if_arb.sv
// N-to-1 native register bus arbiter with per-port one-entry capture
// buffers, round-robin grant and downstream ack timeout.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : upstream ports + downstream port (slave modport)
//   busy        : transaction in flight (ISSUE/WAIT/RESP)
//   grant_id    : last granted port
//   timeout_evt : one-cycle pulse when a downstream ack timed out
module reg_native_if_arb
  import reg_native_arb_pkg::*;
#(
  parameter int N_PORTS        = 4,
  parameter int BUS_ADDR_WIDTH = 64,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                       clk,
  input  logic                       rst,
  reg_native_if_arb_if.slave         bus,
  output logic                       busy,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       timeout_evt
);
  localparam int AW      = BUS_ADDR_WIDTH;
  localparam int DW      = BUS_DATA_WIDTH;
  localparam int IW      = $clog2(N_PORTS);
  localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  arb_state_e                  r_state;
  logic [IW-1:0]               r_ptr, r_gid;
  logic [N_PORTS-1:0]          r_gnt_oh, r_ack;
  logic [CW-1:0]               r_cnt;
  logic                        r_dn_req, r_dn_wr, r_dn_rd, r_dn_ns;
  logic [AW-1:0]               r_dn_addr;
  logic [DW-1:0]               r_dn_wdata, r_rdata;
  logic                        r_err, r_to_evt;

  logic [N_PORTS-1:0]          w_pend, w_wr, w_rd, w_ns, w_gnt_oh;
  logic [N_PORTS-1:0][AW-1:0]  w_addr;
  logic [N_PORTS-1:0][DW-1:0]  w_wdata;
  logic [IW-1:0]               w_gnt_idx;
  logic                        w_expire;

  // Per-port capture buffer; the pending bit drops at the end of RESP.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cap
    logic          r_pend, r_wr, r_rd, r_ns;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pend  <= 1'b0;
        r_wr    <= 1'b0;
        r_rd    <= 1'b0;
        r_ns    <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
      end else if (bus.up_req_vld[gi] && !r_pend) begin
        r_pend  <= 1'b1;
        r_wr    <= bus.up_wr_en[gi];
        r_rd    <= bus.up_rd_en[gi];
        r_ns    <= bus.up_non_sec[gi];
        r_addr  <= bus.up_addr[gi*AW +: AW];
        r_wdata <= bus.up_wr_data[gi*DW +: DW];
      end else if (r_state == S_RESP && r_gid == IW'(gi)) begin
        r_pend  <= 1'b0;
      end
    end

    assign w_pend[gi]  = r_pend;
    assign w_wr[gi]    = r_wr;
    assign w_rd[gi]    = r_rd;
    assign w_ns[gi]    = r_ns;
    assign w_addr[gi]  = r_addr;
    assign w_wdata[gi] = r_wdata;

    assign bus.up_err[gi]                = r_ack[gi] & r_err;
    assign bus.up_rd_data[gi*DW +: DW]   = r_ack[gi] ? r_rdata : '0;
  end

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .i_pend    (w_pend),
    .i_ptr     (r_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx)
  );

  // r_cnt holds completed WAIT cycles; expiry fires in the cycle that makes
  // it TIMEOUT_CYCLES, so the response lands right after that cycle.
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TO_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= IW'(N_PORTS - 1);
      r_gid      <= '0;
      r_gnt_oh   <= '0;
      r_cnt      <= '0;
      r_dn_req   <= 1'b0;
      r_dn_wr    <= 1'b0;
      r_dn_rd    <= 1'b0;
      r_dn_ns    <= 1'b0;
      r_dn_addr  <= '0;
      r_dn_wdata <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_to_evt   <= 1'b0;
    end else begin
      r_dn_req <= 1'b0;
      r_ack    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_to_evt <= 1'b0;
      case (r_state)
        S_IDLE: if (|w_pend) begin
          r_ptr    <= w_gnt_idx;
          r_gid    <= w_gnt_idx;
          r_gnt_oh <= w_gnt_oh;
          if (is_illegal_cmd(w_wr[w_gnt_idx], w_rd[w_gnt_idx])) begin
            // Never reaches downstream; answer with an error right away.
            r_ack   <= w_gnt_oh;
            r_err   <= 1'b1;
            r_rdata <= DW'(ERR_RD_DATA);
            r_state <= S_RESP;
          end else begin
            r_dn_req   <= 1'b1;
            r_dn_wr    <= w_wr[w_gnt_idx];
            r_dn_rd    <= w_rd[w_gnt_idx];
            r_dn_ns    <= w_ns[w_gnt_idx];
            r_dn_addr  <= w_addr[w_gnt_idx];
            r_dn_wdata <= w_wdata[w_gnt_idx];
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A real ack beats a simultaneous timeout.
          if (bus.dn_ack_vld) begin
            r_ack   <= r_gnt_oh;
            r_err   <= bus.dn_err;
            r_rdata <= bus.dn_rd_data;
            r_state <= S_RESP;
          end else if (w_expire) begin
            r_ack    <= r_gnt_oh;
            r_err    <= 1'b1;
            r_rdata  <= DW'(ERR_RD_DATA);
            r_to_evt <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dn_req_vld = r_dn_req;
  assign bus.dn_wr_en   = r_dn_wr;
  assign bus.dn_rd_en   = r_dn_rd;
  assign bus.dn_non_sec = r_dn_ns;
  assign bus.dn_addr    = r_dn_addr;
  assign bus.dn_wr_data = r_dn_wdata;
  assign bus.up_ack_vld = r_ack;

  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_gid;
  assign timeout_evt = r_to_evt;

  // Upstream must not re-request while its buffer is still occupied.
  a_no_req_while_pend : assert property (@(posedge clk) disable iff (rst)
    ((bus.up_req_vld & w_pend) == '0));

endmodule

// File: tb/tb_reg_native_if_arb.sv
// Directed bench for reg_native_if_arb (4 ports, 64/32-bit bus, timeout 8).
module tb_reg_native_if_arb;
  localparam int N = 4, AW = 64, DW = 32, TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, timeout_evt;
  logic [1:0] grant_id;
  int         total = 0;
  int         bad   = 0;
  int         ord [2] = '{0, 3};

  reg_native_if_arb_if #(.N_PORTS(N), .BUS_ADDR_WIDTH(AW), .BUS_DATA_WIDTH(DW)) bus ();

  reg_native_if_arb #(
    .N_PORTS(N), .BUS_ADDR_WIDTH(AW), .BUS_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic up_clear();
    bus.up_req_vld = '0;
    bus.up_wr_en   = '0;
    bus.up_rd_en   = '0;
    bus.up_non_sec = '0;
    bus.up_addr    = '0;
    bus.up_wr_data = '0;
  endtask

  task automatic up_req(input int p, input logic [63:0] a, input logic wr, input logic rd,
                        input logic [31:0] d);
    bus.up_req_vld[p]          = 1'b1;
    bus.up_wr_en[p]            = wr;
    bus.up_rd_en[p]            = rd;
    bus.up_addr[p*AW +: AW]    = a;
    bus.up_wr_data[p*DW +: DW] = d;
  endtask

  task automatic wait_dn(input string tag);
    int n;
    n = 0;
    while (!bus.dn_req_vld && n < 20) begin
      tick();
      n++;
    end
    chk(tag, bus.dn_req_vld, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    up_clear();
    bus.dn_ack_vld = 1'b0;
    bus.dn_err     = 1'b0;
    bus.dn_rd_data = '0;
    tick();
    tick();
    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_toevt", timeout_evt, 0);
    chk("rst_dnreq", bus.dn_req_vld, 0);
    chk("rst_dnaddr", bus.dn_addr, 0);
    chk("rst_upack", bus.up_ack_vld, 0);
    chk("rst_uperr", bus.up_err, 0);
    chk("rst_uprd", bus.up_rd_data, 0);
    rst = 1'b0;

    // single read, port 2
    up_req(2, 64'h40, 1'b0, 1'b1, 32'h0);
    tick();
    up_clear();
    chk("rd_idle_nodn", bus.dn_req_vld, 0);
    tick();
    chk("rd_dnreq", bus.dn_req_vld, 1);
    chk("rd_dnaddr", bus.dn_addr, 128'h40);
    chk("rd_dnrd", bus.dn_rd_en, 1);
    chk("rd_dnwr", bus.dn_wr_en, 0);
    chk("rd_gid", grant_id, 2);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_dnreq_pulse", bus.dn_req_vld, 0);
    tick();
    tick();
    bus.dn_ack_vld = 1'b1;
    bus.dn_rd_data = 32'hDEADBEEF;
    chk("rd_noack_yet", bus.up_ack_vld, 0);
    tick();
    bus.dn_ack_vld = 1'b0;
    bus.dn_rd_data = '0;
    chk("rd_upack", bus.up_ack_vld, 4'b0100);
    chk("rd_updata", bus.up_rd_data, {32'h0, 32'hDEADBEEF, 64'h0});
    chk("rd_uperr", bus.up_err, 0);
    tick();
    chk("rd_done", {busy, bus.up_ack_vld}, 0);

    // contention after reset: order 0,1,2,3 then 0,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) up_req(i, 64'h100 + 64'(i), 1'b0, 1'b1, 32'h0);
    tick();
    up_clear();
    for (int k = 0; k < N; k++) begin
      wait_dn($sformatf("ct_dn%0d", k));
      chk($sformatf("ct_gid%0d", k), grant_id, 128'(k));
      chk($sformatf("ct_addr%0d", k), bus.dn_addr, 128'h100 + 128'(k));
      tick();
      bus.dn_ack_vld = 1'b1;
      bus.dn_rd_data = 32'hA0000000 + 32'(k);
      tick();
      bus.dn_ack_vld = 1'b0;
      chk($sformatf("ct_ack%0d", k), bus.up_ack_vld, 128'(1) << k);
      chk($sformatf("ct_data%0d", k), bus.up_rd_data, (128'hA0000000 + 128'(k)) << (32 * k));
    end
    tick();
    up_req(0, 64'h200, 1'b0, 1'b1, 32'h0);
    up_req(3, 64'h203, 1'b0, 1'b1, 32'h0);
    tick();
    up_clear();
    for (int j = 0; j < 2; j++) begin
      wait_dn($sformatf("ct2_dn%0d", j));
      chk($sformatf("ct2_gid%0d", j), grant_id, 128'(ord[j]));
      tick();
      bus.dn_ack_vld = 1'b1;
      tick();
      bus.dn_ack_vld = 1'b0;
      chk($sformatf("ct2_ack%0d", j), bus.up_ack_vld, 128'(1) << ord[j]);
    end
    bus.dn_rd_data = '0;
    tick();

    // timeout on a write from port 1
    up_req(1, 64'h80, 1'b1, 1'b0, 32'hCAFE0001);
    tick();
    up_clear();
    tick();
    chk("to_dnreq", bus.dn_req_vld, 1);
    chk("to_dnwr", {bus.dn_wr_en, bus.dn_rd_en}, 2'b10);
    chk("to_dnwdata", bus.dn_wr_data, 32'hCAFE0001);
    for (int j = 0; j < TO; j++) begin
      tick();
      chk($sformatf("to_wait%0d", j), {busy, timeout_evt, bus.up_ack_vld}, 6'b100000);
    end
    tick();
    chk("to_evt", timeout_evt, 1);
    chk("to_ack", bus.up_ack_vld, 4'b0010);
    chk("to_err", bus.up_err, 4'b0010);
    chk("to_data", bus.up_rd_data, 0);
    tick();
    chk("to_evt_pulse", {timeout_evt, busy}, 0);
    tick();
    bus.dn_ack_vld = 1'b1;
    bus.dn_err     = 1'b1;
    bus.dn_rd_data = 32'h0BADF00D;
    tick();
    bus.dn_ack_vld = 1'b0;
    bus.dn_err     = 1'b0;
    bus.dn_rd_data = '0;
    chk("to_late_ack", {busy, bus.up_ack_vld, bus.up_err}, 0);

    // ack in the same cycle as expiry: ack wins
    up_req(3, 64'hC0, 1'b0, 1'b1, 32'h0);
    tick();
    up_clear();
    tick();
    chk("bd_dnreq", bus.dn_req_vld, 1);
    repeat (TO) tick();
    bus.dn_ack_vld = 1'b1;
    bus.dn_rd_data = 32'h12345678;
    chk("bd_waiting", {busy, bus.up_ack_vld}, 5'b10000);
    tick();
    bus.dn_ack_vld = 1'b0;
    bus.dn_rd_data = '0;
    chk("bd_noevt", timeout_evt, 0);
    chk("bd_ack", bus.up_ack_vld, 4'b1000);
    chk("bd_err", bus.up_err, 0);
    chk("bd_data", bus.up_rd_data, {32'h12345678, 96'h0});
    tick();
    chk("bd_idle", busy, 0);

    // illegal commands: both set (port 1), both clear (port 0)
    up_req(1, 64'h10, 1'b1, 1'b1, 32'h55);
    tick();
    up_clear();
    chk("il1_nodn_a", bus.dn_req_vld, 0);
    tick();
    chk("il1_nodn_b", bus.dn_req_vld, 0);
    chk("il1_ack", bus.up_ack_vld, 4'b0010);
    chk("il1_err", bus.up_err, 4'b0010);
    chk("il1_data", bus.up_rd_data, 0);
    chk("il1_gid", grant_id, 1);
    tick();
    chk("il1_done", {bus.dn_req_vld, busy, bus.up_ack_vld}, 0);
    up_req(0, 64'h20, 1'b0, 1'b0, 32'h0);
    tick();
    up_clear();
    tick();
    chk("il0_ack", {bus.dn_req_vld, bus.up_ack_vld, bus.up_err}, 9'b0_0001_0001);
    tick();

    // reset while in WAIT; capture during reset is dropped
    up_req(0, 64'h300, 1'b0, 1'b1, 32'h0);
    tick();
    up_clear();
    tick();
    chk("rw_dnreq", bus.dn_req_vld, 1);
    tick();
    tick();
    chk("rw_busy", busy, 1);
    rst = 1'b1;
    up_req(2, 64'h400, 1'b0, 1'b1, 32'h0);
    tick();
    up_clear();
    chk("rw_status", {busy, grant_id, timeout_evt}, 0);
    chk("rw_dn", {bus.dn_req_vld, bus.dn_rd_en, bus.dn_wr_en, bus.dn_addr}, 0);
    chk("rw_up", {bus.up_ack_vld, bus.up_err, bus.up_rd_data}, 0);
    rst = 1'b0;
    bus.dn_ack_vld = 1'b1;
    bus.dn_rd_data = 32'h77777777;
    tick();
    bus.dn_ack_vld = 1'b0;
    bus.dn_rd_data = '0;
    chk("rw_late_ack", {busy, bus.up_ack_vld}, 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("rw_quiet%0d", j), {busy, bus.dn_req_vld, bus.up_ack_vld}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
